// File: rtl/subpix_sum_sched_pkg.sv
// subpix_sum_sched_pkg
//   Shared definitions for the column-sum scheduler: one-hot direction codes
//   driven to the datapath, the datapath latency, and the record types used
//   for tracking issued beats and buffering results.
package subpix_sum_sched_pkg;

  // One-hot window-select codes understood by the column-sum datapath.
  localparam logic [3:0] ST_135_180 = 4'b0001;
  localparam logic [3:0] ST_0_45    = 4'b0010;
  localparam logic [3:0] ST_90_135  = 4'b0100;
  localparam logic [3:0] ST_45_90   = 4'b1000;
  // Code presented whenever no edge beat is issued.
  localparam logic [3:0] ST_IDLE    = ST_0_45;

  // Fixed datapath latency from window-in to column sums out.
  localparam int DP_LAT = 3;

  // Column-sum width produced by the datapath.
  localparam int SUM_W  = 11;

  // Coordinates are carried at this width inside the records; the top level
  // zero-extends its CW-bit coordinates in and truncates them back out, so
  // CW may be anything up to MAX_CW.
  localparam int MAX_CW = 16;

  typedef struct packed {
    logic [SUM_W-1:0]  sl;
    logic [SUM_W-1:0]  sm;
    logic [SUM_W-1:0]  sr;
    logic [3:0]        state;
    logic [MAX_CW-1:0] x;
    logic [MAX_CW-1:0] y;
  } result_t;

  typedef struct packed {
    logic              valid;
    logic [3:0]        state;
    logic [MAX_CW-1:0] x;
    logic [MAX_CW-1:0] y;
  } track_t;

endpackage

// File: rtl/sched_result_fifo.sv
// sched_result_fifo
//   Synchronous FIFO with occupancy count. The head entry is shown on rdata
//   combinationally; rdata reads as zero while the FIFO is empty so that the
//   block outputs are zero after reset.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write one entry (caller guarantees not full)
//   pop           remove the head entry (caller guarantees not empty)
//   rdata         head entry, zero when empty
//   count         number of stored entries, 0..DEPTH
module sched_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = (count != '0) ? mem[rptr] : '0;

endmodule

// File: rtl/subpix_sum_sched.sv
// subpix_sum_sched
//   Scheduler and flow controller for the 3-stage column-sum datapath.
//   Each accepted beat with in_edge set is issued: its gradient direction is
//   classified combinationally onto dp_state in the same cycle, and its
//   {state, x, y} is tracked for DP_LAT cycles until the datapath sums come
//   back and are captured into an output FIFO. Admission is credit based so
//   that the non-stallable datapath can never overflow the FIFO.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready          input beat handshake
//   in_edge, in_gx, in_gy      edge flag and signed gradients
//   in_x, in_y                 pixel coordinates
//   dp_state                   one-hot window select to datapath
//   dp_sl, dp_sm, dp_sr        datapath column sums (DP_LAT after issue)
//   out_valid/out_ready        result handshake
//   out_sl..out_y, out_state   head result record
//   busy                       anything in flight or buffered
//   issue_cnt                  wrapping count of issued edge beats
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. out_valid and the out_* record stay stable
// until transferred; in_ready is a function of internal occupancy only and
// never looks at in_valid.
module subpix_sum_sched
  import subpix_sum_sched_pkg::*;
#(
  parameter int GW    = 11,
  parameter int CW    = 11,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_edge,
  input  logic signed [GW-1:0] in_gx,
  input  logic signed [GW-1:0] in_gy,
  input  logic [CW-1:0]        in_x,
  input  logic [CW-1:0]        in_y,
  output logic [3:0]           dp_state,
  input  logic [SUM_W-1:0]     dp_sl,
  input  logic [SUM_W-1:0]     dp_sm,
  input  logic [SUM_W-1:0]     dp_sr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SUM_W-1:0]     out_sl,
  output logic [SUM_W-1:0]     out_sm,
  output logic [SUM_W-1:0]     out_sr,
  output logic [3:0]           out_state,
  output logic [CW-1:0]        out_x,
  output logic [CW-1:0]        out_y,
  output logic                 busy,
  output logic [15:0]          issue_cnt
);

  localparam int CNTW = $clog2(DEPTH) + 1;
  // One extra bit so fifo_count + inflight (up to DEPTH + DP_LAT) fits.
  localparam int OCCW = CNTW + 1;

  // ---------------------------------------------------------------------
  // Direction classification
  // ---------------------------------------------------------------------
  // Magnitudes at GW+1 bits so that the most negative gradient has a
  // representable absolute value.
  logic [GW:0] gx_e, gy_e, ax, ay;
  logic        lt, opp;
  logic [3:0]  cls;

  always_comb begin
    gx_e = {in_gx[GW-1], in_gx};
    gy_e = {in_gy[GW-1], in_gy};
    ax   = gx_e[GW] ? (~gx_e + 1'b1) : gx_e;
    ay   = gy_e[GW] ? (~gy_e + 1'b1) : gy_e;
    lt   = ay < ax;
    // Zero has a clear sign bit, so it counts as positive here.
    opp  = in_gx[GW-1] ^ in_gy[GW-1];
    case ({lt, opp})
      2'b11:   cls = ST_135_180;
      2'b10:   cls = ST_0_45;
      2'b01:   cls = ST_90_135;
      default: cls = ST_45_90;
    endcase
  end

  // ---------------------------------------------------------------------
  // Admission
  // ---------------------------------------------------------------------
  logic            fire, issue;
  logic [CNTW-1:0] fifo_count;
  logic [OCCW-1:0] inflight, occ;
  track_t          trk [DP_LAT];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < DP_LAT; i++) begin
      inflight = inflight + OCCW'(trk[i].valid);
    end
  end

  // Every beat in flight already owns a FIFO slot, so counting it here is
  // what guarantees the capture push always finds room. Non-edge beats are
  // also held off when no credit is left, which is conservative but simple.
  assign occ      = OCCW'(fifo_count) + inflight;
  assign in_ready = occ < OCCW'(DEPTH);
  assign fire     = in_valid & in_ready;
  assign issue    = fire & in_edge;
  assign dp_state = issue ? cls : ST_IDLE;

  // ---------------------------------------------------------------------
  // Tracking shift register, aligned with the datapath pipeline
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DP_LAT; i++) trk[i] <= '0;
    end else begin
      trk[0].valid <= issue;
      trk[0].state <= cls;
      trk[0].x     <= MAX_CW'(in_x);
      trk[0].y     <= MAX_CW'(in_y);
      for (int i = 1; i < DP_LAT; i++) trk[i] <= trk[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
    end else if (issue) begin
      issue_cnt <= issue_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Capture and output FIFO
  // ---------------------------------------------------------------------
  result_t cap, head;
  logic    push, pop;

  always_comb begin
    cap.sl    = dp_sl;
    cap.sm    = dp_sm;
    cap.sr    = dp_sr;
    cap.state = trk[DP_LAT-1].state;
    cap.x     = trk[DP_LAT-1].x;
    cap.y     = trk[DP_LAT-1].y;
  end

  assign push = trk[DP_LAT-1].valid;
  assign pop  = out_valid & out_ready;

  sched_result_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(result_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (cap),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_sl    = head.sl;
  assign out_sm    = head.sm;
  assign out_sr    = head.sr;
  assign out_state = head.state;
  assign out_x     = head.x[CW-1:0];
  assign out_y     = head.y[CW-1:0];
  assign busy      = (inflight != '0) | (fifo_count != '0);

endmodule
